gcd_bus_frontend: RTL
=====================

Name: gcd_bus_frontend

Overview:
- CPU-bus slave register bank that sits directly upstream of the GCD engine and owns the A1, A2, W and S registers.
- Decodes bus writes into operand and control registers and issues a held start request to the engine.
- Generates the engine clock-enable, captures the engine result into W on done, and exposes W on gpio_out.
- Maintains the status register S, including busy, done, error, overrun and a completion counter.

Parameters:
- BASE_ADDR, 16'h0100, base of the register window.
- CLK_DIV, 1, clk_en asserted once every CLK_DIV clk cycles; 1 means every cycle; legal range 1..255.
- CNT_W, 8, width of the completion counter in S.

Ports:
- clk  in  1  system clock, 1 kHz nominal.
- n_reset  in  1  asynchronous active-low reset.
- saddress  in  16  bus address.
- srd  in  1  bus read strobe, level, synchronous to clk.
- swr  in  1  bus write strobe, level, synchronous to clk.
- sdata_in  in  32  bus write data.
- sdata_out  out  32  bus read data, registered.
- gpio_out  out  32  mirror of W.
- eng_clk_en  out  1  clock-enable to the engine.
- eng_start  out  1  start request, held until acknowledged.
- eng_a  out  32  operand A1.
- eng_b  out  32  operand A2.
- eng_working  in  1  engine busy.
- eng_done  in  1  one-clk done pulse.
- eng_result  in  32  GCD result, valid while eng_done=1.

Behaviour:
- Reset: clk and n_reset form a single clock domain; reset is asynchronous, active-low.
  - n_reset=0 immediately clears all registers.
  - sdata_out, gpio_out, eng_a, eng_b, W, A1, A2, S all go to 0.
  - eng_start=0; eng_clk_en=0; prescaler=0.
- Register map, offsets from BASE_ADDR:
  - +0x0 A1, RW.
  - +0x4 A2, RW.
  - +0x8 CTRL, W only; bit0=start; reads return 0.
  - +0xC W, RO.
  - +0x10 S, RO.
  - Any other address: writes ignored, reads return 0.
- Strobe edges:
  - srd and swr are registered each clk.
  - An access occurs in the cycle where strobe=1 and its previous value was 0; exactly one access per strobe pulse.
  - If both rise in the same cycle, the write is performed and the read is ignored.
- Write timing:
  - A1/A2 update the cycle after the edge, even while busy.
  - The running operation is unaffected because the engine already latched its operands.
- Read timing:
  - sdata_out is loaded the cycle after the edge and held until the next read.
  - A read of W clears S.done in that same cycle.
- S layout:
  - [0] busy = eng_start | eng_working.
  - [1] done, sticky.
  - [2] err_zero, sticky.
  - [3] overrun, sticky.
  - [15:8] completion count, CNT_W bits, wraps 0xFF->0x00.
  - [31:16] 0.
- Start handling (CTRL write with bit0=1):
  - If busy=1: set overrun, nothing else changes.
  - Else if A1==0 or A2==0: set err_zero, no start. This prevents an engine livelock on a zero operand.
  - Else:
    - eng_a<=A1, eng_b<=A2, eng_start<=1.
    - Clear done, err_zero and overrun.
  - A CTRL write with bit0=0 has no effect.
- Start handshake:
  - eng_start stays 1 until a cycle where eng_working=1; it drops the next cycle.
  - eng_a and eng_b are stable while eng_start=1.
- Completion (eng_done=1):
  - W<=eng_result and gpio_out<=eng_result in the same cycle.
  - done<=1; count+=1.
  - If done is set and a W read occur in the same cycle, the set wins.
  - If eng_done coincides with a CTRL start, S.busy is evaluated before the update, so overrun applies only if eng_working or eng_start is still 1.
- Prescaler:
  - Counter runs 0..CLK_DIV-1.
  - eng_clk_en=1 exactly when the counter equals CLK_DIV-1.
  - With CLK_DIV=1, eng_clk_en is constantly 1 after reset release.
- Reset mid-operation: everything returns to reset values; the engine is reset by the same n_reset.

Test Plan:
- Write A1=48, A2=18, CTRL=1 -> eng_start rises next clk; S.busy=1; after eng_done, W=6, gpio_out=6, S=0x0000_0102.
- Write A1=0, A2=7, CTRL=1 -> eng_start stays 0; S=0x0000_0004; then a valid start clears bit2.
- During an active op, CTRL=1 -> S[3]=1; W and count are unchanged by the rejected start; the first op still completes with the correct result.
- Read BASE+0x20 and read CTRL -> sdata_out=0; holding srd high for 5 cycles yields a single access, and a W read clears S[1].
- CLK_DIV=4 -> eng_clk_en pulses every 4th clk; eng_start is held across non-enabled cycles until eng_working=1.
- Assert n_reset=0 mid-op -> all outputs 0 immediately; after release S=0 and gpio_out=0; 256 completions wrap count to 0.

Source files
------------

// File: rtl/gcd_bus_frontend.sv
// gcd_bus_frontend: CPU-bus slave register bank in front of the GCD engine.
// Owns operands A1/A2, result W and status S. Issues a held start request
// to the engine, captures its result, and generates the engine clock-enable.
module gcd_bus_frontend #(
   parameter logic [15:0] BASE_ADDR = 16'h0100,
   parameter int unsigned CLK_DIV   = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   output logic [31:0] gpio_out,
   output logic        eng_clk_en,
   output logic        eng_start,
   output logic [31:0] eng_a,
   output logic [31:0] eng_b,
   input  logic        eng_working,
   input  logic        eng_done,
   input  logic [31:0] eng_result
);

   localparam logic [15:0] ADDR_A1   = BASE_ADDR;
   localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0004;
   localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0008;
   localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h000C;
   localparam logic [15:0] ADDR_S    = BASE_ADDR + 16'h0010;
   localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_srd_q, r_swr_q;
   logic [31:0]      r_a1, r_a2, r_w, r_sdata_out;
   logic [31:0]      r_eng_a, r_eng_b;
   logic             r_eng_start;
   logic             r_done, r_err, r_ovr;
   logic [CNT_W-1:0] r_count;
   logic [7:0]       r_pre;
   logic             r_clk_en;

   logic        w_wr_edge, w_rd_edge;
   logic        w_start_req, w_busy, w_zero_op, w_start_ok, w_rd_w;
   logic [7:0]  w_pre_nxt;
   logic [31:0] w_status, w_rd_data;

   // A write edge masks a simultaneous read edge so only the write happens.
   assign w_wr_edge   = swr & ~r_swr_q;
   assign w_rd_edge   = srd & ~r_srd_q & ~w_wr_edge;
   assign w_start_req = w_wr_edge & (saddress == ADDR_CTRL) & sdata_in[0];
   // Busy is taken from the pre-update state, so a done in the same cycle
   // does not make a start look idle.
   assign w_busy      = r_eng_start | eng_working;
   assign w_zero_op   = (r_a1 == 32'd0) | (r_a2 == 32'd0);
   assign w_start_ok  = w_start_req & ~w_busy & ~w_zero_op;
   assign w_rd_w      = w_rd_edge & (saddress == ADDR_W);
   assign w_pre_nxt   = (r_pre == DIV_LAST) ? 8'd0 : r_pre + 8'd1;

   // Assemble status word and the read-data mux.
   always_comb begin
      w_status              = '0;
      w_status[0]           = w_busy;
      w_status[1]           = r_done;
      w_status[2]           = r_err;
      w_status[3]           = r_ovr;
      w_status[8 +: CNT_W]  = r_count;
      w_rd_data             = '0;
      case (saddress)
         ADDR_A1: w_rd_data = r_a1;
         ADDR_A2: w_rd_data = r_a2;
         ADDR_W:  w_rd_data = r_w;
         ADDR_S:  w_rd_data = w_status;
         default: w_rd_data = '0;
      endcase
   end

   // Strobe history for edge detection.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_srd_q <= 1'b0;
         r_swr_q <= 1'b0;
      end else begin
         r_srd_q <= srd;
         r_swr_q <= swr;
      end
   end

   // Operand registers; writable at any time, the engine holds its own copy.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_a1 <= '0;
         r_a2 <= '0;
      end else if (w_wr_edge) begin
         if (saddress == ADDR_A1) r_a1 <= sdata_in;
         if (saddress == ADDR_A2) r_a2 <= sdata_in;
      end
   end

   // Registered read data, held until the next read access.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)       r_sdata_out <= '0;
      else if (w_rd_edge) r_sdata_out <= w_rd_data;
   end

   // Start request: launched with operand snapshot, held until engine busy.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_eng_start <= 1'b0;
         r_eng_a     <= '0;
         r_eng_b     <= '0;
      end else if (w_start_ok) begin
         r_eng_start <= 1'b1;
         r_eng_a     <= r_a1;
         r_eng_b     <= r_a2;
      end else if (r_eng_start && eng_working) begin
         r_eng_start <= 1'b0;
      end
   end

   // Result capture and sticky status; a done set beats any clear.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_w     <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ovr   <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_start_req) begin
            if (w_busy) begin
               r_ovr <= 1'b1;
            end else if (w_zero_op) begin
               r_err <= 1'b1;
            end else begin
               r_err <= 1'b0;
               r_ovr <= 1'b0;
            end
         end
         if (eng_done) begin
            r_w     <= eng_result;
            r_done  <= 1'b1;
            r_count <= r_count + CNT_ONE;
         end else if (w_start_ok || w_rd_w) begin
            r_done  <= 1'b0;
         end
      end
   end

   // Prescaler; clock-enable is registered so it stays low during reset.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_pre    <= 8'd0;
         r_clk_en <= 1'b0;
      end else begin
         r_pre    <= w_pre_nxt;
         r_clk_en <= (w_pre_nxt == DIV_LAST);
      end
   end

   assign sdata_out  = r_sdata_out;
   assign gpio_out   = r_w;
   assign eng_clk_en = r_clk_en;
   assign eng_start  = r_eng_start;
   assign eng_a      = r_eng_a;
   assign eng_b      = r_eng_b;

endmodule
